// File: rtl/gf180mcu_fd_sc_mcu7t5v0__idle_sleep_ctl.sv
// Idle-driven sleep controller.
// The block counts consecutive idle samples and raises a sleep request once
// THRESH of them have been seen. It then runs a four-phase handshake with the
// power controller: SLPREQ rises, SLPACK rises, SLPREQ falls, SLPACK falls.
// WAKEUP pulses for one cycle when the block returns to ACTIVE from WAKE.
// Every output is a flop, so no input reaches an output combinationally.
module gf180mcu_fd_sc_mcu7t5v0__idle_sleep_ctl #(
  parameter int THRESH = 16,
  parameter int CNTW   = 8
) (
`ifdef USE_POWER_PINS
  inout  wire             VDD,
  inout  wire             VSS,
`endif
  input  logic            CLK,
  input  logic            RST,
  input  logic            IDLE,
  input  logic            SLPACK,
  output logic            SLPREQ,
  output logic            ASLEEP,
  output logic            WAKEUP,
  output logic [CNTW-1:0] IDLECNT
);

  // IDLECNT saturates at this value while a sleep request is outstanding.
  localparam logic [CNTW-1:0] LAST = CNTW'(THRESH - 1);

  typedef enum logic [2:0] {
    ACTIVE = 3'd0,
    COUNT  = 3'd1,
    REQ    = 3'd2,
    SLEEP  = 3'd3,
    WAKE   = 3'd4
  } state_t;

  state_t state;

  // Single-process FSM; outputs are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ACTIVE;
      SLPREQ  <= 1'b0;
      ASLEEP  <= 1'b0;
      WAKEUP  <= 1'b0;
      IDLECNT <= '0;
    end else begin
      // WAKEUP is a pulse: only the WAKE -> ACTIVE transition sets it.
      WAKEUP <= 1'b0;
      case (state)
        ACTIVE: begin
          // SLPACK is ignored here; only IDLE moves the FSM.
          if (IDLE) begin
            if (THRESH == 1) begin
              state   <= REQ;
              SLPREQ  <= 1'b1;
              IDLECNT <= LAST;
            end else begin
              state   <= COUNT;
              IDLECNT <= CNTW'(1);
            end
          end else begin
            IDLECNT <= '0;
          end
        end
        COUNT: begin
          if (!IDLE) begin
            state   <= ACTIVE;
            IDLECNT <= '0;
          end else if (IDLECNT == LAST) begin
            // THRESH-th consecutive idle sample: request sleep, hold count.
            state  <= REQ;
            SLPREQ <= 1'b1;
          end else begin
            IDLECNT <= IDLECNT + CNTW'(1);
          end
        end
        REQ: begin
          // Acknowledge wins over a simultaneous loss of idle.
          if (SLPACK) begin
            state  <= SLEEP;
            ASLEEP <= 1'b1;
          end else if (!IDLE) begin
            state   <= ACTIVE;
            SLPREQ  <= 1'b0;
            IDLECNT <= '0;
          end
        end
        SLEEP: begin
          if (!IDLE) begin
            state   <= WAKE;
            SLPREQ  <= 1'b0;
            ASLEEP  <= 1'b0;
            IDLECNT <= '0;
          end
        end
        WAKE: begin
          // Wait for SLPACK to drop so SLPREQ cannot re-rise mid-handshake.
          if (!SLPACK) begin
            state  <= ACTIVE;
            WAKEUP <= 1'b1;
          end
        end
        default: begin
          state   <= ACTIVE;
          SLPREQ  <= 1'b0;
          ASLEEP  <= 1'b0;
          IDLECNT <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__idle_sleep_ctl.sv
// Directed bench for the idle sleep controller (THRESH=4, CNTW=8).
// Each step drives inputs, pushes the expected registered outputs for the
// next edge onto a scoreboard queue, then pops and compares after the edge.
module tb_gf180mcu_fd_sc_mcu7t5v0__idle_sleep_ctl;

  localparam int THRESH = 4;
  localparam int CNTW   = 8;

  typedef struct packed {
    logic            req;
    logic            asleep;
    logic            wake;
    logic [CNTW-1:0] cnt;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            IDLE = 1'b0;
  logic            SLPACK = 1'b0;
  logic            SLPREQ;
  logic            ASLEEP;
  logic            WAKEUP;
  logic [CNTW-1:0] IDLECNT;

  exp_t   sb[$];
  int     vectors = 0;
  int     miscompares = 0;

  gf180mcu_fd_sc_mcu7t5v0__idle_sleep_ctl #(
    .THRESH(THRESH),
    .CNTW  (CNTW)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .IDLE   (IDLE),
    .SLPACK (SLPACK),
    .SLPREQ (SLPREQ),
    .ASLEEP (ASLEEP),
    .WAKEUP (WAKEUP),
    .IDLECNT(IDLECNT)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, record the expectation, compare after the edge.
  task automatic step(input logic rst, input logic idle, input logic ack,
                      input logic e_req, input logic e_slp, input logic e_wk,
                      input int e_cnt, input string tag);
    exp_t e;
    exp_t obs;
    RST    = rst;
    IDLE   = idle;
    SLPACK = ack;
    e.req    = e_req;
    e.asleep = e_slp;
    e.wake   = e_wk;
    e.cnt    = CNTW'(e_cnt);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e   = sb.pop_front();
    obs = '{SLPREQ, ASLEEP, WAKEUP, IDLECNT};
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: got req=%b asleep=%b wakeup=%b cnt=%0d, want req=%b asleep=%b wakeup=%b cnt=%0d",
             tag, obs.req, obs.asleep, obs.wake, obs.cnt,
             e.req, e.asleep, e.wake, e.cnt);
    end
  endtask

  initial begin
    // Reset overrides active IDLE and SLPACK.
    step(1, 1, 1, 0, 0, 0, 0, "rst0");
    step(1, 1, 1, 0, 0, 0, 0, "rst1");

    // Count up to the threshold, request sleep, hold the request.
    step(0, 1, 0, 0, 0, 0, 1, "cnt1");
    step(0, 1, 0, 0, 0, 0, 2, "cnt2");
    step(0, 1, 0, 0, 0, 0, 3, "cnt3");
    step(0, 1, 0, 1, 0, 0, 3, "req_rise");
    step(0, 1, 0, 1, 0, 0, 3, "req_hold");
    // Abort from REQ when idle drops without acknowledge.
    step(0, 0, 0, 0, 0, 0, 0, "req_abort");

    // Idle broken one short of threshold: request never rises.
    step(0, 1, 0, 0, 0, 0, 1, "short1");
    step(0, 1, 0, 0, 0, 0, 2, "short2");
    step(0, 1, 0, 0, 0, 0, 3, "short3");
    step(0, 0, 0, 0, 0, 0, 0, "short_break");
    step(0, 0, 0, 0, 0, 0, 0, "active_stay");

    // Acknowledge is ignored in ACTIVE and COUNT.
    step(0, 0, 1, 0, 0, 0, 0, "ack_active");
    step(0, 1, 1, 0, 0, 0, 1, "ack_cnt1");
    step(0, 1, 1, 0, 0, 0, 2, "ack_cnt2");
    step(0, 0, 0, 0, 0, 0, 0, "ack_cnt_break");

    // Full four-phase handshake.
    step(0, 1, 0, 0, 0, 0, 1, "hs_cnt1");
    step(0, 1, 0, 0, 0, 0, 2, "hs_cnt2");
    step(0, 1, 0, 0, 0, 0, 3, "hs_cnt3");
    step(0, 1, 0, 1, 0, 0, 3, "hs_req");
    step(0, 1, 1, 1, 1, 0, 3, "hs_sleep");
    step(0, 1, 0, 1, 1, 0, 3, "hs_sleep_noack");
    step(0, 1, 1, 1, 1, 0, 3, "hs_sleep_hold");
    step(0, 0, 1, 0, 0, 0, 0, "hs_wake");
    step(0, 0, 1, 0, 0, 0, 0, "hs_wake_hold");
    step(0, 1, 0, 0, 0, 1, 0, "hs_wakeup");
    step(0, 0, 0, 0, 0, 0, 0, "hs_wakeup_end");

    // Acknowledge and idle loss on the same edge: acknowledge wins.
    step(0, 1, 0, 0, 0, 0, 1, "race_cnt1");
    step(0, 1, 0, 0, 0, 0, 2, "race_cnt2");
    step(0, 1, 0, 0, 0, 0, 3, "race_cnt3");
    step(0, 1, 0, 1, 0, 0, 3, "race_req");
    step(0, 0, 1, 1, 1, 0, 3, "race_sleep");
    step(0, 0, 1, 0, 0, 0, 0, "race_wake");
    step(0, 0, 0, 0, 0, 1, 0, "race_wakeup");
    step(0, 0, 0, 0, 0, 0, 0, "race_wakeup_end");

    // Reset mid-handshake from SLEEP, then counting restarts from 1.
    step(0, 1, 0, 0, 0, 0, 1, "rsl_cnt1");
    step(0, 1, 0, 0, 0, 0, 2, "rsl_cnt2");
    step(0, 1, 0, 0, 0, 0, 3, "rsl_cnt3");
    step(0, 1, 0, 1, 0, 0, 3, "rsl_req");
    step(0, 1, 1, 1, 1, 0, 3, "rsl_sleep");
    step(1, 1, 1, 0, 0, 0, 0, "rsl_reset");
    step(0, 1, 1, 0, 0, 0, 1, "rsl_restart1");
    step(0, 1, 0, 0, 0, 0, 2, "rsl_restart2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
